// File: rtl/edic_clk_ctrl_pkg.sv
// edic_clk_ctrl_pkg: controller state encoding, shared by the clock-enable generator
//   state_t: HALT=0 RUN=1 STEP_INSTR=2 BREAK=3; these values are also what o_state shows
package edic_clk_ctrl_pkg;
  typedef enum logic [1:0] {
    HALT       = 2'd0,
    RUN        = 2'd1,
    STEP_INSTR = 2'd2,
    BREAK      = 2'd3
  } state_t;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-FF synchroniser, stability counter and press pulse for the step button
//   clk, rst  clock, asynchronous active-high reset
//   btn       raw button level, asynchronous
//   step_req  one-cycle pulse when the accepted level goes 0->1
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step_req
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level, done;
  logic [CW-1:0] cnt;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // cnt counts consecutive samples that differ from the accepted level; any agreeing sample restarts it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync     <= '0;
      level    <= 1'b0;
      cnt      <= '0;
      step_req <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      cnt      <= (sync[1] == level || done) ? '0 : cnt + CW'(1);
      level    <= (sync[1] != level && done) ? sync[1] : level;
      step_req <= sync[1] & ~level & done;
    end
endmodule

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: CPU clock-enable generator with run, cycle step, instruction step and PC breakpoint
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_btnStep                    raw step button (asynchronous)
//   i_swInstrNCycle              1 = instruction step, 0 = cycle step (asynchronous)
//   i_swStepNRun                 1 = step mode, 0 = run mode (asynchronous)
//   i_swEnableBreakpoint         breakpoint armed (asynchronous)
//   i_breakpointAddress, i_pc    breakpoint PC and next-instruction PC
//   i_instrDone                  current microcycle ends the instruction
//   o_cpuClkEn                   registered one-cycle CPU advance enable
//   o_state                      HALT/RUN/STEP_INSTR/BREAK for display
//   o_cycleCount                 enable pulses since reset, only with CLK_STEP_CTRL_CYCLE_COUNT_EN
module clk_step_ctrl
  import edic_clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIV         = 1,
  parameter int ADDR_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btnStep,
  input  logic              i_swInstrNCycle,
  input  logic              i_swStepNRun,
  input  logic              i_swEnableBreakpoint,
  input  logic [ADDR_W-1:0] i_breakpointAddress,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_instrDone,
  output logic              o_cpuClkEn,
  output logic [1:0]        o_state
`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]       o_cycleCount
`endif
);
  localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  logic [2:0] sw_s1, sw_s2;
  logic [1:0] rdy;
  logic live, sw_instr, sw_step, sw_bp, step_req, tick, done, hit, en_d, set_mask, mask;
  logic [DW-1:0] div;
  state_t state, nxt;
  assign {sw_bp, sw_step, sw_instr} = sw_s2;
  // synchronisers come out of reset at 0, which would read as run mode; hold HALT until they carry real switch values
  assign live = rdy[1];
  assign tick = div == DW'(RUN_DIV - 1);
  assign done = o_cpuClkEn & i_instrDone;
  assign hit  = done & sw_bp & ~mask & (i_pc == i_breakpointAddress);
  assign o_state = state;
  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(i_clk),
    .rst(i_rst),
    .btn(i_btnStep),
    .step_req(step_req)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      rdy        <= '0;
      state      <= HALT;
      o_cpuClkEn <= 1'b0;
      mask       <= 1'b0;
      div        <= '0;
    end else begin
      sw_s1      <= {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle};
      sw_s2      <= sw_s1;
      rdy        <= {rdy[0], 1'b1};
      state      <= nxt;
      o_cpuClkEn <= en_d;
      mask       <= set_mask | (mask & ~done);
      div        <= (nxt != state || tick) ? '0 : div + DW'(1);
    end
  // a hit or a completed instruction suppresses the next enable so the CPU stops before the following instruction
  always_comb begin
    nxt      = state;
    en_d     = 1'b0;
    set_mask = 1'b0;
    case (state)
      HALT:
        if (live) begin
          if (!sw_step) nxt = RUN;
          else if (step_req) begin
            nxt  = sw_instr ? STEP_INSTR : HALT;
            en_d = !sw_instr;
          end
        end
      RUN:
        if (hit) nxt = BREAK;
        else if (sw_step) nxt = HALT;
        else en_d = tick;
      STEP_INSTR:
        if (done) nxt = HALT;
        else if (!sw_step) nxt = RUN;
        else en_d = tick;
      BREAK:
        if (sw_step) nxt = HALT;
        else if (step_req) begin
          nxt      = RUN;
          set_mask = 1'b1;
        end
      default: nxt = HALT;
    endcase
  end
`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
  assign o_cycleCount = cycle_count;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cycle_count <= '0;
    else if (o_cpuClkEn) cycle_count <= cycle_count + 32'd1;
`endif
endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: directed bench for clk_step_ctrl with a 3-microcycle CPU model
module tb_clk_step_ctrl;
  logic clk = 1'b0, rst = 1'b1, btn = 1'b0, sw_instr = 1'b0, sw_step = 1'b1, sw_bp = 1'b0;
  logic cpu_rst = 1'b1;
  logic [15:0] bp = 16'h0028, pc, next_pc;
  logic [7:0] uc;
  logic instr_done, en, en4;
  logic [1:0] st, st4;
  int checks = 0, errors = 0, pulses = 0, pulses4 = 0, ilen = 3;
`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc, cyc4;
`endif

  always #5 clk = ~clk;

  // CPU model: pc is the executing instruction, loop 0x20..0x30, ilen microcycles each
  assign next_pc    = (pc == 16'h0030) ? 16'h0020 : pc + 16'd2;
  assign instr_done = (uc == 8'(ilen - 1));
  always @(posedge clk)
    if (cpu_rst) begin
      uc <= 8'd0;
      pc <= 16'h0020;
    end else if (en) begin
      uc <= instr_done ? 8'd0 : uc + 8'd1;
      if (instr_done) pc <= next_pc;
    end

  always @(negedge clk) begin
    if (en) pulses <= pulses + 1;
    if (en4) pulses4 <= pulses4 + 1;
  end

  clk_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_btnStep(btn), .i_swInstrNCycle(sw_instr),
    .i_swStepNRun(sw_step), .i_swEnableBreakpoint(sw_bp), .i_breakpointAddress(bp),
    .i_pc(next_pc), .i_instrDone(instr_done), .o_cpuClkEn(en), .o_state(st)
`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
    , .o_cycleCount(cyc)
`endif
  );

  clk_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(4), .ADDR_W(16)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_btnStep(btn), .i_swInstrNCycle(sw_instr),
    .i_swStepNRun(sw_step), .i_swEnableBreakpoint(1'b0), .i_breakpointAddress(bp),
    .i_pc(next_pc), .i_instrDone(instr_done), .o_cpuClkEn(en4), .o_state(st4)
`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
    , .o_cycleCount(cyc4)
`endif
  );

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int rel);
    btn = 1'b1; cyc_wait(hold);
    btn = 1'b0; cyc_wait(rel);
  endtask

  task automatic press_bouncy();
    btn = 1'b1; cyc_wait(2); btn = 1'b0; cyc_wait(2);
    btn = 1'b1; cyc_wait(2); btn = 1'b0; cyc_wait(1);
    btn = 1'b1; cyc_wait(20); btn = 1'b0; cyc_wait(20);
  endtask

  task automatic model_reset();
    cpu_rst = 1'b1; @(negedge clk); cpu_rst = 1'b0;
  endtask

  task automatic wait_state(input bit four, input logic [1:0] s, input int budget, output bit ok);
    int n = 0;
    while ((four ? st4 : st) !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = ((four ? st4 : st) === s);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      btn = i[0]; sw_instr = i[1]; sw_step = ~i[0]; sw_bp = i[2];
      @(negedge clk);
      checks++;
      if (en !== 1'b0 || st !== 2'd0 || en4 !== 1'b0 || st4 !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: en=%b st=%0d en4=%b st4=%0d, expected all 0", i, en, st, en4, st4);
      end
    end
    btn = 1'b0; sw_instr = 1'b0; sw_step = 1'b1; sw_bp = 1'b0;
    @(negedge clk);
    rst = 1'b0; cpu_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (en !== 1'b0 || st !== 2'd0 || en4 !== 1'b0 || st4 !== 2'd0) begin
        errors++;
        $display("FAIL reset_release[%0d]: en=%b st=%0d en4=%b st4=%0d, expected all 0", i, en, st, en4, st4);
      end
    end
  endtask

  task automatic test_cycle_step();
    int p0, p4;
    p0 = pulses; p4 = pulses4;
    press_bouncy();
    checks++;
    if (pulses !== p0 + 1) begin errors++; $display("FAIL cycle_step_bouncy: pulses=%0d expected %0d", pulses - p0, 1); end
    checks++;
    if (pulses4 !== p4 + 1) begin errors++; $display("FAIL cycle_step_div4: pulses=%0d expected %0d", pulses4 - p4, 1); end
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL cycle_step_state: state=%0d expected 0", st); end
    press(8, 20);
    checks++;
    if (pulses !== p0 + 2) begin errors++; $display("FAIL cycle_step_second: pulses=%0d expected %0d", pulses - p0, 2); end
  endtask

  task automatic test_instr_step();
    int p0;
    bit ok;
    sw_instr = 1'b1; ilen = 3;
    model_reset(); cyc_wait(3);
    p0 = pulses;
    press(8, 20);
    checks++;
    if (pulses !== p0 + 3) begin errors++; $display("FAIL instr_step_pulses: pulses=%0d expected 3", pulses - p0); end
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL instr_step_halt: state=%0d expected 0", st); end
    ilen = 30;
    model_reset(); cyc_wait(3);
    p0 = pulses;
    btn = 1'b1;
    wait_state(1'b0, 2'd2, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL instr_step_enter: state=%0d expected 2", st); end
    btn = 1'b0; cyc_wait(8);
    btn = 1'b1; cyc_wait(8);
    btn = 1'b0;
    wait_state(1'b0, 2'd0, 60, ok);
    cyc_wait(20);
    checks++;
    if (pulses !== p0 + 30) begin errors++; $display("FAIL instr_step_press_during: pulses=%0d expected 30", pulses - p0); end
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL instr_step_long_halt: state=%0d expected 0", st); end
  endtask

  task automatic test_breakpoint();
    int p0;
    bit ok;
    sw_instr = 1'b0; ilen = 3;
    model_reset();
    bp = 16'h0028; sw_bp = 1'b1;
    cyc_wait(3);
    p0 = pulses;
    sw_step = 1'b0;
    wait_state(1'b0, 2'd3, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_first_halt: state=%0d expected 3", st); end
    checks++;
    if (pulses !== p0 + 12) begin errors++; $display("FAIL bp_first_pulses: pulses=%0d expected 12", pulses - p0); end
    checks++;
    if (pc !== 16'h0028 || uc !== 8'd0) begin
      errors++; $display("FAIL bp_not_executed: pc=%h uc=%0d expected pc=0028 uc=0", pc, uc);
    end
    p0 = pulses;
    cyc_wait(8);
    checks++;
    if (pulses !== p0 || st !== 2'd3) begin
      errors++; $display("FAIL bp_stopped: extra pulses=%0d state=%0d expected 0 and 3", pulses - p0, st);
    end
    btn = 1'b1; cyc_wait(10); btn = 1'b0;
    checks++;
    if (st !== 2'd1) begin errors++; $display("FAIL bp_resume: state=%0d expected 1", st); end
    wait_state(1'b0, 2'd3, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_second_halt: state=%0d expected 3", st); end
    checks++;
    if (pulses !== p0 + 27) begin errors++; $display("FAIL bp_second_pulses: pulses=%0d expected 27", pulses - p0); end
    sw_step = 1'b1;
    cyc_wait(4);
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL bp_to_halt: state=%0d expected 0", st); end
    sw_bp = 1'b0;
    cyc_wait(10);
  endtask

  task automatic test_run_div();
    int n = 0;
    sw_step = 1'b0;
    while (en4 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (en4 !== 1'b1) begin errors++; $display("FAIL div_first_pulse: en4=%b expected 1", en4); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (en4 !== ((k % 4) == 0)) begin
        errors++; $display("FAIL div_period[%0d]: en4=%b expected %b", k, en4, (k % 4) == 0);
      end
    end
    sw_step = 1'b1;
    cyc_wait(2);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (en4 !== 1'b0) begin errors++; $display("FAIL div_stop[%0d]: en4=%b expected 0", k, en4); end
    end
    checks++;
    if (st4 !== 2'd0) begin errors++; $display("FAIL div_halt: state=%0d expected 0", st4); end
  endtask

  task automatic test_reset_mid_step();
    int n = 0, p4;
    bit ok;
    sw_instr = 1'b1; ilen = 30;
    model_reset(); cyc_wait(3);
    btn = 1'b1;
    wait_state(1'b1, 2'd2, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_step_enter: state=%0d expected 2", st4); end
    while (en4 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    rst = 1'b1; cpu_rst = 1'b1; btn = 1'b0;
    @(negedge clk);
    p4 = pulses4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (en4 !== 1'b0 || st4 !== 2'd0) begin
        errors++; $display("FAIL rst_step_hold[%0d]: en4=%b st4=%0d expected 0/0", k, en4, st4);
      end
    end
    sw_instr = 1'b0;
    rst = 1'b0; cpu_rst = 1'b0;
    cyc_wait(15);
    checks++;
    if (pulses4 !== p4 || st4 !== 2'd0) begin
      errors++; $display("FAIL rst_step_after: extra pulses=%0d st4=%0d expected 0 and 0", pulses4 - p4, st4);
    end
  endtask

`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    checks++;
    if (cyc !== 32'd0) begin errors++; $display("FAIL count_reset: count=%0d expected 0", cyc); end
    for (int k = 0; k < 10; k++) press(8, 12);
    checks++;
    if (cyc !== 32'd10) begin errors++; $display("FAIL count_ten: count=%0d expected 10", cyc); end
    force dut.cycle_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycle_count;
    press(8, 12);
    checks++;
    if (cyc !== 32'd0) begin errors++; $display("FAIL count_wrap: count=%h expected 00000000", cyc); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cycle_step();
    test_instr_step();
    test_breakpoint();
    test_run_div();
    test_reset_mid_step();
`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
